// File: rtl/mult_pkg.sv
// Shared encodings for the sequential Booth multiplier: FSM states and Booth step opcodes.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_e;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/subtract of M into ACC, then an arithmetic
// shift right of {ACC,Q,q_1} by one bit.
module booth_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH+1:0] acc_i,
  input  logic [WIDTH:0]   q_i,
  input  logic             q_1_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH+1:0] acc_o,
  output logic [WIDTH:0]   q_o,
  output logic             q_1_o
);
  import mult_pkg::*;

  booth_op_e        op;
  logic [WIDTH+1:0] m_ext;
  logic [WIDTH+1:0] sum;

  // M is already WIDTH+1 bits with its sign; one more copy forms the guard bit.
  assign m_ext = {m_i[WIDTH], m_i};

  always_comb begin
    op = BOOTH_NOP;
    unique case ({q_i[0], q_1_i})
      2'b01:   op = BOOTH_ADD;
      2'b10:   op = BOOTH_SUB;
      default: op = BOOTH_NOP;
    endcase
  end

  always_comb begin
    sum = acc_i;
    case (op)
      BOOTH_ADD: sum = acc_i + m_ext;
      BOOTH_SUB: sum = acc_i - m_ext;
      default:   sum = acc_i;
    endcase
  end

  assign acc_o = {sum[WIDTH+1], sum[WIDTH+1:1]};
  assign q_o   = {sum[0], q_i[WIDTH:1]};
  assign q_1_o = q_i[0];

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier, one step per clock, signed or unsigned per operation.
// start/done handshake; result_out holds until the next done_out pulse.
module booth_seq_multiplier #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_in,
  input  logic               signed_in,
  input  logic [WIDTH-1:0]   A_in,
  input  logic [WIDTH-1:0]   B_in,
  output logic               busy_out,
  output logic               done_out,
  output logic [2*WIDTH-1:0] result_out
);
  import mult_pkg::*;

  localparam int unsigned CntW = $clog2(WIDTH + 2);

  state_e           state_q;
  logic [CntW-1:0]  count_q;
  logic [WIDTH+1:0] acc_q;
  logic [WIDTH:0]   q_q;
  logic             q_1_q;
  logic [WIDTH:0]   m_q;

  logic [WIDTH+1:0] acc_nxt;
  logic [WIDTH:0]   q_nxt;
  logic             q_1_nxt;

  booth_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc_i (acc_q),
    .q_i   (q_q),
    .q_1_i (q_1_q),
    .m_i   (m_q),
    .acc_o (acc_nxt),
    .q_o   (q_nxt),
    .q_1_o (q_1_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      q_q        <= '0;
      q_1_q      <= 1'b0;
      m_q        <= '0;
      busy_out   <= 1'b0;
      done_out   <= 1'b0;
      result_out <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_out <= 1'b0;
          if (start_in) begin
            // Extending to WIDTH+1 bits lets one signed datapath serve both modes.
            m_q      <= {signed_in & A_in[WIDTH-1], A_in};
            q_q      <= {signed_in & B_in[WIDTH-1], B_in};
            q_1_q    <= 1'b0;
            acc_q    <= '0;
            count_q  <= CntW'(WIDTH + 1);
            busy_out <= 1'b1;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q   <= acc_nxt;
          q_q     <= q_nxt;
          q_1_q   <= q_1_nxt;
          count_q <= count_q - CntW'(1);
          if (count_q == CntW'(1)) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Low 2*WIDTH bits of {ACC,Q}; the upper bits only carry extension.
          result_out <= {acc_q[WIDTH-2:0], q_q};
          done_out   <= 1'b1;
          busy_out   <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
